// File: rtl/skey_gen.sv
// skey_gen: iterative Twofish RS-matrix S-vector generator for 128-bit keys
module skey_gen (
   input  logic         clk,
   input  logic         reset,
   input  logic         ce,
   input  logic [127:0] key,
   output logic [31:0]  keys0,
   output logic [31:0]  keys1,
   output logic         zero
);

   // GF(2^8) multiply, shift-and-add reduced by x^8+x^6+x^3+x^2+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [8:0] t;
      p = 8'h00;
      t = {1'b0, a};
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t[7:0];
         t = t << 1;
         if (t[8]) t = t ^ 9'h14D;
      end
      return p;
   endfunction

   // RS matrix column j packed as {r3, r2, r1, r0}
   function automatic logic [31:0] rs_col(input logic [2:0] j);
      case (j)
         3'd0:    return 32'hA402A401;
         3'd1:    return 32'h55A156A4;
         3'd2:    return 32'h87FC8255;
         3'd3:    return 32'h5AC1F387;
         3'd4:    return 32'h58471E5A;
         3'd5:    return 32'hDBAEC658;
         3'd6:    return 32'h9E3D68DB;
         default: return 32'h0319E59E;
      endcase
   endfunction

   logic [3:0]  r_cnt;
   logic [31:0] r_acc0;
   logic [31:0] r_acc1;
   logic [2:0]  w_j;
   logic [31:0] w_coef;
   logic [7:0]  w_m [16];
   logic [7:0]  w_m0;
   logic [7:0]  w_m1;
   logic [31:0] w_prod0;
   logic [31:0] w_prod1;

   genvar g;
   generate
      for (g = 0; g < 16; g++) begin : g_byte
         assign w_m[g] = key[127-8*g -: 8];
      end
   endgenerate

   // column index j = 8 - cnt, taken modulo 8 since cnt is 1..8 while stepping
   assign w_j    = 3'd0 - r_cnt[2:0];
   assign w_coef = rs_col(w_j);
   assign w_m0   = w_m[{1'b0, w_j}];
   assign w_m1   = w_m[{1'b1, w_j}];

   generate
      for (g = 0; g < 4; g++) begin : g_row
         assign w_prod0[8*g +: 8] = gf_mul(w_coef[8*g +: 8], w_m0);
         assign w_prod1[8*g +: 8] = gf_mul(w_coef[8*g +: 8], w_m1);
      end
   endgenerate

   assign zero  = (r_cnt == 4'd0);
   assign keys0 = r_acc0;
   assign keys1 = r_acc1;

   // step counter and accumulators; reset restarts, finished state freezes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= 4'd8;
         r_acc0 <= 32'h0;
         r_acc1 <= 32'h0;
      end else if (ce && !zero) begin
         r_cnt  <= r_cnt - 4'd1;
         r_acc0 <= r_acc0 ^ w_prod0;
         r_acc1 <= r_acc1 ^ w_prod1;
      end
   end

endmodule

// File: tb/tb_skey_gen.sv
// tb_skey_gen: scoreboard bench for the RS-matrix S-vector generator
module tb_skey_gen;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         ce = 1'b0;
   logic [127:0] key = '0;
   logic [31:0]  keys0;
   logic [31:0]  keys1;
   logic         zero;

   int total = 0;
   int bad = 0;
   logic [63:0] sb [$];

   logic [7:0] rs [4][8] = '{
      '{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E},
      '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5},
      '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19},
      '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03}
   };

   skey_gen dut (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .key   (key),
      .keys0 (keys0),
      .keys1 (keys1),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   // carry-less product followed by polynomial long-division reduction
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--)
         if (p[i]) p = p ^ (15'h14D << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [63:0] ref_rs(input logic [127:0] k);
      logic [31:0] s0;
      logic [31:0] s1;
      s0 = '0;
      s1 = '0;
      for (int r = 0; r < 4; r++)
         for (int j = 0; j < 8; j++) begin
            s0[8*r +: 8] = s0[8*r +: 8] ^ ref_mul(rs[r][j], k[127-8*j -: 8]);
            s1[8*r +: 8] = s1[8*r +: 8] ^ ref_mul(rs[r][j], k[63-8*j -: 8]);
         end
      return {s0, s1};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // one full computation: gap_len idle cycles after gap_at steps, reset pulse after abort_at steps
   task automatic run(input string tag, input logic [127:0] k, input int gap_at,
                      input int gap_len, input int abort_at);
      int n;
      int cyc;
      int gaps;
      logic aborted;
      logic [63:0] hold;
      logic [63:0] exp;
      key = k;
      reset = 1'b1;
      ce = 1'b0;
      tick();
      reset = 1'b0;
      chk({tag, "_rst_zero"}, 64'(zero), 64'd0);
      chk({tag, "_rst_keys"}, {keys0, keys1}, 64'd0);
      n = 0;
      cyc = 0;
      gaps = 0;
      aborted = 1'b0;
      while (!zero && cyc < 200) begin
         if (!aborted && abort_at > 0 && n == abort_at) begin
            aborted = 1'b1;
            reset = 1'b1;
            ce = 1'b1;
            tick();
            reset = 1'b0;
            chk({tag, "_abort_keys"}, {keys0, keys1}, 64'd0);
            chk({tag, "_abort_zero"}, 64'(zero), 64'd0);
            n = 0;
         end else if (n == gap_at && gaps < gap_len) begin
            ce = 1'b0;
            hold = {keys0, keys1};
            tick();
            gaps++;
            chk({tag, "_gap_hold"}, {keys0, keys1}, hold);
         end else begin
            ce = ~zero;
            tick();
            n++;
            if (n < 8) chk({tag, "_early_zero"}, 64'(zero), 64'd0);
         end
         cyc++;
      end
      ce = 1'b0;
      chk({tag, "_steps"}, 64'(n), 64'd8);
      chk({tag, "_zero"}, 64'(zero), 64'd1);
      if (sb.size() > 0) begin
         exp = sb.pop_front();
         chk({tag, "_keys"}, {keys0, keys1}, exp);
      end else
         chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
   endtask

   initial begin
      logic [63:0] hold;
      logic [127:0] rk;
      tick();
      sb.push_back(64'h0);
      run("zerokey", 128'h0, -1, 0, 0);
      sb.push_back({32'hA402A401, 32'h0});
      run("m0_01", 128'h01 << 120, -1, 0, 0);
      sb.push_back({32'h0, 32'hA402A401});
      run("m8_01", 128'h01 << 56, -1, 0, 0);
      sb.push_back({32'h0319E59E, 32'h0});
      run("m7_01", 128'h01 << 64, -1, 0, 0);
      sb.push_back({32'h05040502, 32'h0});
      run("m0_02", 128'h02 << 120, -1, 0, 0);
      sb.push_back(ref_rs(128'h2b7e151628aed2a6abf7158809cf4f3d));
      run("aes", 128'h2b7e151628aed2a6abf7158809cf4f3d, -1, 0, 0);
      sb.push_back(ref_rs(128'h2b7e151628aed2a6abf7158809cf4f3d));
      run("gap", 128'h2b7e151628aed2a6abf7158809cf4f3d, 4, 3, 0);
      hold = {keys0, keys1};
      ce = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("done_keys", {keys0, keys1}, hold);
         chk("done_zero", 64'(zero), 64'd1);
      end
      ce = 1'b0;
      sb.push_back(ref_rs(128'h0123456789abcdeffedcba9876543210));
      run("abort", 128'h0123456789abcdeffedcba9876543210, -1, 0, 3);
      for (int t = 0; t < 3; t++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         sb.push_back(ref_rs(rk));
         run("rand", rk, t + 2, t + 1, 0);
      end
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/skey_gen.md
Name: skey_gen

Overview:
- Twofish S-vector key generator for 128-bit keys (k=2).
- Multiplies each 64-bit key half by the Reed-Solomon (RS) matrix over GF(2^8) to produce the two 32-bit S words used by the h-function/S-box stage of the key schedule.
- Iterative: processes one key-byte column per enabled clock and takes 8 enabled clocks to complete.
- Raises `zero` when finished; upstream logic drives `ce` as the inverse of `zero`.

Parameters:
- none (key size fixed at 128 bits)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; advances computation one step
- key  in  128  cipher key; must be held stable from reset release until `zero`=1
- keys0  out  32  S0 word (from key bytes m0..m7)
- keys1  out  32  S1 word (from key bytes m8..m15)
- zero  out  1  high when step counter = 0, i.e. keys0/keys1 valid

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Byte mapping: m_i = key[127-8i -: 8], so m0 = key[127:120] and m15 = key[7:0].
- GF(2^8) arithmetic:
  - Field polynomial x^8+x^6+x^3+x^2+1 (0x14D).
  - Addition is XOR.
  - Multiply is shift-and-add with reduction by 0x14D whenever bit 8 is set.
- RS matrix rows (columns j=0..7):
  - r0: 01 A4 55 87 5A 58 DB 9E
  - r1: A4 56 82 F3 1E C6 68 E5
  - r2: 02 A1 FC C1 47 AE 3D 19
  - r3: A4 55 87 5A 58 DB 9E 03
- Results:
  - S0 byte r = XOR over j of RS[r][j]*m_j.
  - S1 byte r = XOR over j of RS[r][j]*m_(8+j).
- Packing: keys0 = {s0_3, s0_2, s0_1, s0_0}, with byte r=0 in bits [7:0]; keys1 is packed the same way.
- State:
  - 4-bit step counter `cnt`.
  - Two 32-bit accumulators acc0 and acc1.
  - keys0 = acc0 and keys1 = acc1, driven directly from registers.
- Reset (synchronous, priority over `ce`): cnt <= 8, acc0 <= 0, acc1 <= 0. After reset zero=0, keys0=0, keys1=0.
- Step, on a rising edge with ce=1 and cnt != 0:
  - j = 8 - cnt.
  - acc0 byte r ^= RS[r][j]*m_j, for all r.
  - acc1 byte r ^= RS[r][j]*m_(8+j).
  - cnt <= cnt - 1.
- ce=0: all state holds; ce may be dropped and reasserted at any point without affecting the result.
- zero = (cnt == 0), combinational from the counter register.
- Latency: zero rises after the 8th enabled edge following reset release.
- When cnt == 0, ce is ignored: no wrap, and outputs stay frozen until the next reset.
- Reset asserted mid-computation aborts the computation and restarts from cnt=8 with cleared accumulators.
- key changes during computation are not detected; the result is undefined.
- Implementation: one combinational column multiplier per S word (4 constant multiplies selected by j), XOR-accumulated.

Test Plan:
- Zero key: reset, then 8 cycles with ce=1 -> keys0=0x00000000, keys1=0x00000000, zero=1 exactly after 8th edge and 0 before it.
- key with only m0=0x01 (key=128'h01<<120) -> keys0=0xA402A401, keys1=0; key with only m8=0x01 -> keys1=0xA402A401, keys0=0.
- key with only m7=0x01 -> keys0=0x0319E59E; key with only m0=0x02 -> keys0=0x05040502 (checks 0x14D reduction: 2*A4=05).
- Gap test: drive ce=~zero with ce held low for 3 cycles after step 4 -> zero rises after 8 enabled edges; result identical to the gap-free run; outputs frozen while ce=0.
- Done/reset test: keep ce=1 for 5 extra cycles after zero -> outputs unchanged, zero stays 1. Assert reset mid-run at step 3 -> outputs 0, zero=0, and the next 8 steps give the correct result.
- Key 128'h2b7e151628aed2a6abf7158809cf4f3d with ce=~zero -> zero rises after 8 enabled edges; keys0/keys1 match a software RS-matrix reference model.
